mac_accum_requant: RTL and testbench
====================================

// Module: mac_accum_requant
// PURPOSE
//  Downstream stage of the signed 32x32 Vedic multiplier in the Extended DLX TinyML datapath.
//  Accepts a stream of signed 64-bit products and accumulates a dot product of programmed length.
//  Rescales the sum by an arithmetic right shift with rounding, saturates to signed 32 bits,
//  and hands the result to the DLX writeback under a valid/ready handshake.
// PARAMETERS
//  ACC_W  80  accumulator width; must be >= 64+LEN_W so the accumulator never wraps
//  OUT_W  32  result width, signed
//  LEN_W  16  width of the dot-product length field
// PORTS
//  clk         in   1      rising-edge clock
//  rst_n       in   1      asynchronous, active-low reset
//  start       in   1      begin new dot product; sampled only in IDLE
//  len         in   LEN_W  number of products to accumulate; latched on start
//  shift       in   6      right-shift amount, 0..63; latched on start
//  prod_valid  in   1      upstream product valid
//  prod_ready  out  1      block accepts a product this cycle
//  prod        in   64     signed product from the 32x32 multiplier
//  res_valid   out  1      result valid
//  res_ready   in   1      downstream accepts the result
//  res         out  OUT_W  scaled, saturated result
//  busy        out  1      high in every state except IDLE
//  ovf         out  1      sticky saturation flag; cleared on accepted start
// BEHAVIOUR
//  Reset (async, any state): state=IDLE, acc=0, cnt=0, res=0, res_valid=0, prod_ready=0, busy=0, ovf=0.
//  FSM states: IDLE, ACCUM, SCALE, HOLD.
//   IDLE: start=1 -> acc=0, cnt=0, ovf=0, latch len/shift.
//         Next state: ACCUM if len!=0; SCALE if len==0, giving res=0.
//   ACCUM: prod_ready=1. On prod_valid&prod_ready: acc += sext(prod), cnt++.
//          When the accepted product is number len (cnt==len-1): next state SCALE. Stalls indefinitely while prod_valid=0.
//   SCALE: prod_ready=0. Single cycle; res, ovf and res_valid registered at its end; next state HOLD.
//   HOLD: res_valid=1, res stable. On res_ready -> IDLE, res_valid drops the next cycle.
//  Latency: the last product handshake at edge k gives res_valid=1 after edge k+1.
//   start with len=0 gives res_valid=1 two edges after start.
//  Scaling:
//   t = acc + (shift!=0 ? 1<<(shift-1) : 0)   (round half up)
//   t = t >>> shift (arithmetic)
//   Saturate to [-2^31, 2^31-1]; ovf=1 if clamped.
//  start while busy: ignored, no effect.
//  prod_valid outside ACCUM: ignored; prod_ready=0.
//  res_ready outside HOLD: ignored.
//  Full-range products never wrap the accumulator: ACC_W >= 64+LEN_W.
// CONFIGURATION
//  MAC_RELU_EN defined: after saturation, a negative result is forced to 0; ovf is not affected by the ReLU.
//  MAC_RELU_EN undefined: signed saturated result is passed unchanged.
// STRUCTURE
//  Shared package mac_pkg:
//   - state encoding localparams (IDLE=2'd0, ACCUM=2'd1, SCALE=2'd2, HOLD=2'd3)
//   - default ACC_W/OUT_W/LEN_W
//   - OUT_MAX/OUT_MIN constants
//  Sub-module mac_round_sat: combinational round, shift, saturate and optional ReLU.
//   Ports: acc, shift -> res, sat.
//   The FSM, counter and handshake registers stay in the top module.
// TESTING
//  1. len=3, shift=0; prods 5, -2, 10 -> res=13, ovf=0, res_valid one edge after the 3rd handshake.
//  2. len=2, shift=0; prod=64'h7FFF_FFFF_0000_0000 twice -> res=32'h7FFF_FFFF, ovf=1.
//     Repeat with 64'h8000_0000_0000_0000 -> res=32'h8000_0000, ovf=1.
//  3. len=1, shift=4; prod=24 -> res=2. Then prod=-24 -> res=-1. Then prod=-25 -> res=-2.
//  4. Back-pressure: res_ready=0 for 5 cycles in HOLD -> res and res_valid stable, prod_ready=0.
//     A start pulse during HOLD is ignored; completion occurs on res_ready=1.
//  5. Reset mid-ACCUM after 2 of 4 products -> all outputs 0, state IDLE.
//     A fresh start with len=1, prod=7 then gives res=7.
//  6. len=0 -> res=0, res_valid two edges after start.
//     With MAC_RELU_EN: len=1, prod=-7 -> res=0, ovf=0.
//     Without MAC_RELU_EN: same stimulus -> res=-7.

Source files
------------

// File: rtl/mac_pkg.sv
// mac_pkg: shared state encoding, default widths and saturation bounds for the MAC requantiser.
package mac_pkg;
    localparam int ACC_W_DEF = 80;
    localparam int OUT_W_DEF = 32;
    localparam int LEN_W_DEF = 16;

    localparam logic [OUT_W_DEF-1:0] OUT_MAX = {1'b0, {(OUT_W_DEF-1){1'b1}}};
    localparam logic [OUT_W_DEF-1:0] OUT_MIN = {1'b1, {(OUT_W_DEF-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        SCALE = 2'd2,
        HOLD  = 2'd3
    } state_t;
endpackage

// File: rtl/mac_round_sat.sv
// mac_round_sat: round-half-up arithmetic right shift and signed saturation of the accumulator.
// Defining MAC_RELU_EN clamps negative results to zero after saturation.
module mac_round_sat
    import mac_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEF,
    parameter int OUT_W = OUT_W_DEF
) (
    input  logic [ACC_W-1:0] acc,
    input  logic [5:0]       shift,
    output logic [OUT_W-1:0] res,
    output logic             sat
);
    logic [ACC_W:0]   rnd;
    logic [ACC_W:0]   t;
    logic [ACC_W:0]   s;
    logic [OUT_W-1:0] clamp;
    logic             hi;
    logic             lo;

    // one extra bit of headroom so the rounding increment can never wrap
    assign rnd = (shift == 6'd0) ? '0 : ({{ACC_W{1'b0}}, 1'b1} << (shift - 6'd1));
    assign t   = {acc[ACC_W-1], acc} + rnd;
    assign s   = $unsigned($signed(t) >>> shift);

    // in range only when every bit above the output sign bit matches the sign
    assign hi    = !s[ACC_W] && (|s[ACC_W-1:OUT_W-1]);
    assign lo    = s[ACC_W] && !(&s[ACC_W-1:OUT_W-1]);
    assign sat   = hi | lo;
    assign clamp = hi ? OUT_MAX : (lo ? OUT_MIN : s[OUT_W-1:0]);

`ifdef MAC_RELU_EN
    assign res = clamp[OUT_W-1] ? '0 : clamp;
`else
    assign res = clamp;
`endif
endmodule

// File: rtl/mac_accum_requant.sv
// mac_accum_requant: accumulates a programmed-length stream of signed 64-bit products, then
// rescales/saturates to 32 bits and offers it under valid/ready. Optional ReLU via MAC_RELU_EN.
module mac_accum_requant
    import mac_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEF,
    parameter int OUT_W = OUT_W_DEF,
    parameter int LEN_W = LEN_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic [5:0]       shift,
    input  logic             prod_valid,
    output logic             prod_ready,
    input  logic [63:0]      prod,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [OUT_W-1:0] res,
    output logic             busy,
    output logic             ovf
);
    state_t           state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [5:0]       shift_q, shift_d;
    logic [OUT_W-1:0] res_q, res_d;
    logic             ovf_q, ovf_d;
    logic [OUT_W-1:0] rs_res;
    logic             rs_sat;

    mac_round_sat #(.ACC_W(ACC_W), .OUT_W(OUT_W)) u_round_sat (
        .acc   (acc_q),
        .shift (shift_q),
        .res   (rs_res),
        .sat   (rs_sat)
    );

    assign prod_ready = (state_q == ACCUM);
    assign res_valid  = (state_q == HOLD);
    assign busy       = (state_q != IDLE);
    assign res        = res_q;
    assign ovf        = ovf_q;

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        shift_d = shift_q;
        res_d   = res_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: if (start) begin
                acc_d   = '0;
                cnt_d   = '0;
                ovf_d   = 1'b0;
                len_d   = len;
                shift_d = shift;
                state_d = (len != '0) ? ACCUM : SCALE;
            end
            ACCUM: if (prod_valid) begin
                acc_d   = acc_q + {{(ACC_W-64){prod[63]}}, prod};
                cnt_d   = cnt_q + LEN_W'(1);
                state_d = (cnt_q == len_q - LEN_W'(1)) ? SCALE : ACCUM;
            end
            SCALE: begin
                res_d   = rs_res;
                ovf_d   = ovf_q | rs_sat;
                state_d = HOLD;
            end
            HOLD: if (res_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            len_q   <= '0;
            shift_q <= '0;
            res_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            shift_q <= shift_d;
            res_q   <= res_d;
            ovf_q   <= ovf_d;
        end
    end
endmodule

// File: tb/tb_mac_accum_requant.sv
// tb_mac_accum_requant: directed bench with an arithmetic reference model of the requantised dot product.
module tb_mac_accum_requant;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] len = '0;
    logic [5:0]  shift = '0;
    logic        prod_valid = 1'b0;
    logic [63:0] prod = '0;
    logic        res_ready = 1'b0;
    logic        prod_ready, res_valid, busy, ovf;
    logic [31:0] res;

    int checks = 0;
    int errors = 0;
    logic signed [63:0] pq[$];
    logic [31:0] exp_res = '0;
    logic        exp_ovf = 1'b0;

    always #5 clk = ~clk;

    mac_accum_requant dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .len        (len),
        .shift      (shift),
        .prod_valid (prod_valid),
        .prod_ready (prod_ready),
        .prod       (prod),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res        (res),
        .busy       (busy),
        .ovf        (ovf)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h at %0t", nm, act, req, $time);
        end
    endtask

    // exact dot product in wide integers, then round/shift/clamp by definition
    function automatic void model(input int sh, output logic [31:0] r, output logic o);
        logic signed [127:0] s;
        logic signed [127:0] mx;
        logic signed [127:0] mn;
        s  = '0;
        mx = 128'sd2147483647;
        mn = -128'sd2147483648;
        foreach (pq[i]) s += pq[i];
        if (sh != 0) s += (128'sd1 <<< (sh - 1));
        s = s >>> sh;
        o = 1'b1;
        if (s > mx) r = 32'h7FFF_FFFF;
        else if (s < mn) r = 32'h8000_0000;
        else begin
            r = s[31:0];
            o = 1'b0;
        end
`ifdef MAC_RELU_EN
        if (r[31]) r = '0;
`endif
    endfunction

    always @(negedge clk) begin
        if (rst_n && res_valid) begin
            chk("model_res", res, exp_res);
            chk("model_ovf", ovf, exp_ovf);
            chk("hold_prod_ready", prod_ready, 0);
            chk("hold_busy", busy, 1);
        end
    end

    task automatic send(input logic [63:0] p, input int gap);
        bit ok = 0;
        repeat (gap) begin @(posedge clk); #1; end
        prod_valid = 1'b1;
        prod = p;
        for (int i = 0; i < 10; i++) begin
            if (prod_ready) begin
                ok = 1;
                @(posedge clk); #1;
                break;
            end
            @(posedge clk); #1;
        end
        prod_valid = 1'b0;
        prod = 64'hDEAD_BEEF_DEAD_BEEF;
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL prod_handshake: prod_ready never rose, expected 1");
        end
    endtask

    task automatic run(input int sh, input logic [31:0] lit_res, input logic lit_ovf,
                       input int hold, input bit poke);
        model(sh, exp_res, exp_ovf);
        len   = 16'(pq.size());
        shift = 6'(sh);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        len   = 16'hFFFF;
        shift = 6'd63;
        foreach (pq[i]) send(pq[i], (i == 1) ? 1 : 0);
        chk("lat_early", res_valid, 0);
        @(posedge clk); #1;
        chk("lat_valid", res_valid, 1);
        chk("lit_res", res, lit_res);
        chk("lit_ovf", ovf, lit_ovf);
        for (int i = 0; i < hold; i++) begin
            start = poke && (i == 1);
            @(posedge clk); #1;
            start = 1'b0;
            chk("bp_valid", res_valid, 1);
            chk("bp_res", res, lit_res);
            chk("bp_prod_ready", prod_ready, 0);
        end
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        chk("done_valid", res_valid, 0);
        chk("done_busy", busy, 0);
        pq.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, expected finish");
        $fatal(1);
    end

    initial begin
        #12;
        chk("rst_res_valid", res_valid, 0);
        chk("rst_prod_ready", prod_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_res", res, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        pq = '{64'sd5, -64'sd2, 64'sd10};
        run(0, 32'd13, 1'b0, 0, 0);
        pq = '{64'sh7FFF_FFFF_0000_0000, 64'sh7FFF_FFFF_0000_0000};
        run(0, 32'h7FFF_FFFF, 1'b1, 0, 0);
        pq = '{64'sh8000_0000_0000_0000, 64'sh8000_0000_0000_0000};
        run(0, 32'h8000_0000, 1'b1, 0, 0);

        pq = '{64'sd24};
        run(4, 32'd2, 1'b0, 0, 0);
`ifdef MAC_RELU_EN
        pq = '{-64'sd24};
        run(4, 32'd0, 1'b0, 0, 0);
        pq = '{-64'sd25};
        run(4, 32'd0, 1'b0, 0, 0);
`else
        pq = '{-64'sd24};
        run(4, 32'hFFFF_FFFF, 1'b0, 0, 0);
        pq = '{-64'sd25};
        run(4, 32'hFFFF_FFFE, 1'b0, 0, 0);
`endif
        pq = '{-64'sd8};
        run(4, 32'd0, 1'b0, 0, 0);
        pq = '{64'sh4000_0000_0000_0000};
        run(62, 32'd1, 1'b0, 0, 0);

        pq = '{64'sd100, 64'sd200};
        run(1, 32'd150, 1'b0, 5, 1);

        len   = 16'd4;
        shift = 6'd0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        send(64'd1, 0);
        send(64'd2, 0);
        rst_n = 1'b0;
        #1;
        chk("arst_res_valid", res_valid, 0);
        chk("arst_prod_ready", prod_ready, 0);
        chk("arst_busy", busy, 0);
        chk("arst_ovf", ovf, 0);
        chk("arst_res", res, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        pq = '{64'sd7};
        run(0, 32'd7, 1'b0, 0, 0);

        pq.delete();
        run(0, 32'd0, 1'b0, 0, 0);
        pq = '{-64'sd7};
`ifdef MAC_RELU_EN
        run(0, 32'd0, 1'b0, 0, 0);
`else
        run(0, 32'hFFFF_FFF9, 1'b0, 0, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
